// File: rtl/sdram_arbit.sv
// sdram_arbit - SDRAM command-bus arbiter.
//
// Sits between the init, auto-refresh, write and read engines and the SDRAM
// pins. Only the init engine drives the bus until init completes. After that,
// one engine at a time owns the bus. Refresh always wins. Refresh requests
// that arrive during a burst are counted, and the burst owner is asked to
// break at its next burst boundary.
//
// Optional build macro: SDRAM_ARBIT_RR_EN
//   defined   - round-robin between write and read when both request
//   undefined - fixed priority, write over read
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   init_cmd/addr/ba, init_end        init engine bus, init-complete pulse
//   aref_req, aref_cmd/addr, aref_end refresh request, refresh bus, done pulse
//   aref_en                           refresh grant
//   wr_req, wr_cmd/addr/ba, wr_end    write engine request, bus, done pulse
//   wr_en, wr_break                   write grant, break request
//   rd_*                              read engine equivalents
//   sdram_cmd/addr/ba                 registered pin outputs
//   arb_state                         one-hot state
//   aref_pend, aref_ovf               queued refreshes, sticky overflow
//
// state | meaning
// IDLE  | waiting for init_end, init engine drives pins
// ARBIT | one-cycle decision slot, NOP on pins
// AREF  | refresh engine owns the bus
// WRITE | write engine owns the bus
// READ  | read engine owns the bus
module sdram_arbit #(
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2,
    parameter int CMD_W  = 4,
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CMD_W-1:0]  init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [BA_W-1:0]   init_ba,
    input  logic              init_end,
    input  logic              aref_req,
    input  logic [CMD_W-1:0]  aref_cmd,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              aref_end,
    output logic              aref_en,
    input  logic              wr_req,
    input  logic [CMD_W-1:0]  wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic              wr_end,
    output logic              wr_en,
    output logic              wr_break,
    input  logic              rd_req,
    input  logic [CMD_W-1:0]  rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic              rd_end,
    output logic              rd_en,
    output logic              rd_break,
    output logic [CMD_W-1:0]  sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [4:0]        arb_state,
    output logic [PEND_W-1:0] aref_pend,
    output logic              aref_ovf
);

    localparam logic [4:0] S_IDLE  = 5'b00001;
    localparam logic [4:0] S_ARBIT = 5'b00010;
    localparam logic [4:0] S_AREF  = 5'b00100;
    localparam logic [4:0] S_WRITE = 5'b01000;
    localparam logic [4:0] S_READ  = 5'b10000;

    localparam logic [CMD_W-1:0]  CMD_NOP  = CMD_W'(4'b0111);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    logic [4:0]        state, next_state;
    logic [CMD_W-1:0]  cmd_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [BA_W-1:0]   ba_nxt;
    logic              pend_inc, pend_dec;

`ifdef SDRAM_ARBIT_RR_EN
    // 1 = write was granted last; resets to read so write wins first
    logic last_wr;

    always_ff @(posedge clk) begin
        if (rst)
            last_wr <= 1'b0;
        else if (state == S_ARBIT && next_state == S_WRITE)
            last_wr <= 1'b1;
        else if (state == S_ARBIT && next_state == S_READ)
            last_wr <= 1'b0;
    end
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (init_end) next_state = S_ARBIT;
            S_ARBIT: begin
                if (aref_pend != '0)
                    next_state = S_AREF;
                else if (wr_req && rd_req) begin
`ifdef SDRAM_ARBIT_RR_EN
                    next_state = last_wr ? S_READ : S_WRITE;
`else
                    next_state = S_WRITE;
`endif
                end
                else if (wr_req)
                    next_state = S_WRITE;
                else if (rd_req)
                    next_state = S_READ;
            end
            S_AREF:  if (aref_end) next_state = S_ARBIT;
            S_WRITE: if (wr_end)   next_state = S_ARBIT;
            S_READ:  if (rd_end)   next_state = S_ARBIT;
            default: next_state = S_IDLE;
        endcase
    end

    // outputs: grants from the current state, pin mux from the next state
    always_comb begin
        aref_en  = (state == S_AREF);
        wr_en    = (state == S_WRITE);
        rd_en    = (state == S_READ);
        cmd_nxt  = CMD_NOP;
        addr_nxt = '0;
        ba_nxt   = '0;
        case (next_state)
            S_IDLE:  begin cmd_nxt = init_cmd; addr_nxt = init_addr; ba_nxt = init_ba; end
            S_AREF:  begin cmd_nxt = aref_cmd; addr_nxt = aref_addr; end
            S_WRITE: begin cmd_nxt = wr_cmd;   addr_nxt = wr_addr;   ba_nxt = wr_ba;   end
            S_READ:  begin cmd_nxt = rd_cmd;   addr_nxt = rd_addr;   ba_nxt = rd_ba;   end
            default: ;
        endcase
    end

    assign arb_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            sdram_cmd  <= CMD_NOP;
            sdram_addr <= '0;
            sdram_ba   <= '0;
            wr_break   <= 1'b0;
            rd_break   <= 1'b0;
        end else begin
            sdram_cmd  <= cmd_nxt;
            sdram_addr <= addr_nxt;
            sdram_ba   <= ba_nxt;
            // drops in the same edge the owner leaves its state
            wr_break   <= (next_state == S_WRITE) && (aref_pend != '0);
            rd_break   <= (next_state == S_READ)  && (aref_pend != '0);
        end
    end

    // a refresh completing while another is requested leaves the count unchanged
    assign pend_inc = aref_req;
    assign pend_dec = aref_end && (state == S_AREF);

    always_ff @(posedge clk) begin
        if (rst) begin
            aref_pend <= '0;
            aref_ovf  <= 1'b0;
        end else if (pend_inc && !pend_dec) begin
            if (aref_pend == PEND_MAX)
                aref_ovf <= 1'b1;
            else
                aref_pend <= aref_pend + 1'b1;
        end else if (pend_dec && !pend_inc && aref_pend != '0) begin
            aref_pend <= aref_pend - 1'b1;
        end
    end

endmodule
